uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..8.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning clk cycles per bit; even and >= 8.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame, 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd; it has effect only with UART_RX_PARITY_EN defined.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rstn input 1 (async active-low reset).
REQ-006 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-007 SHALL have port rx_rdy, input, 1 bit: consumer ready.
REQ-008 SHALL have port rx_vld, output, 1 bit: dout holds a valid byte.
REQ-009 SHALL have port dout, output, DATA_BITS bits: received data.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port par_err, output, 1 bit: one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-013 SHALL pass rxd through a 2-flop synchroniser; all internal references are to the synchronised line.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 SHALL go from IDLE to START on a synchronised high-to-low transition and reset the phase counter to 0.
REQ-016 SHALL decide each bit by 2-of-3 majority of the samples at phase OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, with the decision at phase OVERSAMPLE/2+1.
REQ-017 SHALL return from START to IDLE on a majority-1 start bit (false start) with no error flag.
REQ-018 SHALL, in DATA, shift DATA_BITS decisions LSB-first, then go to PARITY if enabled, otherwise to STOP.
REQ-019 SHALL, in STOP, check STOP_BITS consecutive bits; any majority-0 pulses frame_err, discards the byte, and enters WAIT_IDLE.
REQ-020 SHALL leave WAIT_IDLE for IDLE only after the synchronised rxd is sampled high.
REQ-021 SHALL, on a good final stop decision, load dout and assert rx_vld on the next rising edge, then return to IDLE without waiting for the end of the stop bit.
REQ-022 SHALL hold rx_vld and dout stable until a cycle with rx_vld and rx_rdy both high; rx_vld deasserts on the following edge.
REQ-023 SHALL, when a frame completes while rx_vld is high and rx_rdy is low in that cycle, keep the old dout, pulse overrun, and drop the new byte.
REQ-024 SHALL, when a frame completes in the same cycle the old byte is accepted, load the new byte with rx_vld staying high and no overrun.
REQ-025 SHALL wrap the phase counter from OVERSAMPLE-1 to 0, advancing one bit per wrap.

Reset
REQ-026 SHALL, on rstn low at any time including mid-frame, immediately set FSM=IDLE, counters=0, synchroniser flops=1, rx_vld=0, dout=0, frame_err=0, par_err=0, overrun=0.
REQ-027 SHALL treat the first falling edge seen after rstn deasserts as a new start bit.

Configuration
REQ-028 SHALL, with macro UART_RX_PARITY_EN defined, sample one parity bit after the data; a mismatch against even/odd per PARITY_ODD pulses par_err, discards the byte, then STOP is checked normally.
REQ-029 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and its logic and tie par_err to 0.

Structure
REQ-030 SHALL place the FSM state enum type and the constants PAR_EVEN=0 / PAR_ODD=1 in shared package uart_rx_pkg.
REQ-031 SHALL implement the synchroniser and 3-sample majority voter as sub-module rx_sync_maj, instantiated once.

Verification
REQ-032 SHALL cover, with defaults: frame 0xA5 at 16 clk/bit and rx_rdy=1 -> rx_vld asserted, dout=8'hA5, all error flags 0.
REQ-033 SHALL cover: rx_rdy=0, frames 0x11 then 0x22 -> dout stays 8'h11 with rx_vld high, one overrun pulse; raising rx_rdy -> rx_vld drops one cycle later.
REQ-034 SHALL cover: frame 0x3C with stop bit 0, then line high -> frame_err pulse, no rx_vld; next frame 0x5A is received correctly.
REQ-035 SHALL cover: a 4-cycle low glitch on idle rxd -> no rx_vld and no flags; also a single-cycle high glitch at mid-bit of data 0x00 -> dout=8'h00 (majority).
REQ-036 SHALL cover, with UART_RX_PARITY_EN and PARITY_ODD=0: frame 0x07 with parity bit 0 -> par_err pulse, no rx_vld; the same frame with parity bit 1 -> dout=8'h07.
REQ-037 SHALL cover: rstn pulsed low during data bit 3 -> all outputs 0 immediately; a subsequent frame 0xC3 -> dout=8'hC3.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM state
// encoding and the parity-sense constants.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rx_sync_maj.sv
// Input conditioning for the UART receiver: 2-flop synchroniser on rxd,
// falling-edge detector on the synchronised line, and a 2-of-3 majority
// voter over the samples at phases OVERSAMPLE/2-1, OVERSAMPLE/2 and
// OVERSAMPLE/2+1. The vote is valid during phase OVERSAMPLE/2+1.
module rx_sync_maj #(
  parameter int OVERSAMPLE = 16,
  parameter int PW         = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rxd,
  input  logic [PW-1:0] phase,
  output logic          line,
  output logic          fell,
  output logic          maj
);

  localparam logic [PW-1:0] PH_EARLY = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(OVERSAMPLE / 2);

  logic meta;
  logic line_d;
  logic s_early;
  logic s_mid;

  // Synchronise rxd, keep one cycle of history, capture the first two votes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the line flops reset to the idle level (1) so that releasing
      // reset never looks like a falling edge, i.e. never fakes a start bit.
      meta    <= 1'b1;
      line    <= 1'b1;
      line_d  <= 1'b1;
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the value from
      // before this edge; blocking ones would collapse the 2-flop chain.
      meta   <= rxd;
      line   <= meta;
      line_d <= line;
      if (phase == PH_EARLY) s_early <= line;
      if (phase == PH_MID)   s_mid   <= line;
    end
  end

  assign fell = line_d & ~line;
  assign maj  = (s_early & s_mid) | (s_early & line) | (s_mid & line);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised oversampling UART receiver with a valid/ready output and
// one-cycle frame_err / par_err / overrun pulses.
// Optional feature: define UART_RX_PARITY_EN to receive and check one
// parity bit (sense chosen by PARITY_ODD); otherwise par_err is tied 0.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  input  logic                 rx_rdy,
  output logic                 rx_vld,
  output logic [DATA_BITS-1:0] dout,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 overrun
);

  localparam int              PW        = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0]   PH_DECIDE = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0]   PH_LAST   = PW'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration time.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("DATA_BITS must be 5..8");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("OVERSAMPLE must be even and >= 8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
  localparam logic      PAR_SENSE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  logic par_take;
  logic par_mismatch;
  logic par_bad;
  logic par_err_q;
`else
  localparam rx_state_e AFTER_DATA = STOP;
`endif

  rx_state_e            state;
  rx_state_e            state_n;
  logic [PW-1:0]        phase;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 line;
  logic                 fell;
  logic                 maj;
  logic                 decide;
  logic                 wrap;
  logic                 shift_en;
  logic                 stop_good;
  logic                 frame_bad;
  logic                 deliver;

  rx_sync_maj #(
    .OVERSAMPLE(OVERSAMPLE),
    .PW        (PW)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .rxd  (rxd),
    .phase(phase),
    .line (line),
    .fell (fell),
    .maj  (maj)
  );

  assign decide = (phase == PH_DECIDE);
  assign wrap   = (phase == PH_LAST);

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_n   = state;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_take  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fell) state_n = START;
      end
      START: begin
        if (decide && maj) state_n = IDLE;
        else if (wrap)     state_n = DATA;
      end
      DATA: begin
        shift_en = decide;
        if (wrap && bit_cnt == LAST_BIT) state_n = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        par_take = decide;
        if (wrap) state_n = STOP;
      end
`endif
      STOP: begin
        if (decide) begin
          if (!maj) begin
            frame_bad = 1'b1;
            state_n   = WAIT_IDLE;
          end else if (stop_cnt == STOP_LAST) begin
            stop_good = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, bit-timing counters and the data shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE || wrap) phase <= '0;
      else                       phase <= phase + 1'b1;
      if (state != DATA) bit_cnt <= '0;
      else if (wrap)     bit_cnt <= bit_cnt + 4'd1;
      if (state != STOP) stop_cnt <= 1'b0;
      else if (wrap)     stop_cnt <= stop_cnt + 1'b1;
      if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_mismatch = ((^shreg) ^ maj) != PAR_SENSE;

  // Remember a parity failure until the frame ends; pulse par_err once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_take && par_mismatch;
      if (state == IDLE)                 par_bad <= 1'b0;
      else if (par_take && par_mismatch) par_bad <= 1'b1;
    end
  end

  assign par_err = par_err_q;
  assign deliver = stop_good && !par_bad;
`else
  assign par_err = 1'b0;
  assign deliver = stop_good;
`endif

  // Output holding register with valid/ready handshake and error pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_vld    <= 1'b0;
      dout      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_vld || rx_rdy) begin
          dout   <= shreg;
          rx_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_vld && rx_rdy) begin
        rx_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param at default parameters. Frames are
// driven bit by bit; a frame-level model predicts which bytes must be
// handed over and how many error pulses must appear. Define
// UART_RX_PARITY_EN for both DUT and bench to exercise the parity option.
module tb_uart_rx_param;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int SB = 1;
  localparam int PO = 0;

  logic          clk    = 1'b0;
  logic          rstn   = 1'b1;
  logic          rxd    = 1'b1;
  logic          rx_rdy = 1'b1;
  logic          rx_vld;
  logic [DB-1:0] dout;
  logic          frame_err;
  logic          par_err;
  logic          overrun;

  int checks   = 0;
  int failures = 0;

  int n_ferr = 0, n_perr = 0, n_ovr = 0;
  int e_ferr = 0, e_perr = 0, e_ovr = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx_param #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_BITS (SB),
    .PARITY_ODD(PO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rx_rdy   (rx_rdy),
    .rx_vld   (rx_vld),
    .dout     (dout),
    .frame_err(frame_err),
    .par_err  (par_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Observe handshakes and error pulses on the falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_vld && rx_rdy) got_q.push_back(dout);
      if (frame_err) n_ferr <= n_ferr + 1;
      if (par_err)   n_perr <= n_perr + 1;
      if (overrun)   n_ovr  <= n_ovr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return (PO != 0) ? ~(^d) : (^d);
  endfunction

  // Drive one frame; glitch_bit >= 0 flips that data bit for one cycle near mid-bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input int glitch_bit, input int gap);
    rxd = 1'b0;
    tick(OS);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      if (i == glitch_bit) begin
        tick(OS / 2 + 2);
        rxd = ~d[i];
        tick(1);
        rxd = d[i];
        tick(OS / 2 - 3);
      end else begin
        tick(OS);
      end
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_ok ? good_parity(d) : ~good_parity(d);
    tick(OS);
`endif
    for (int s = 0; s < SB; s++) begin
      rxd = stop_ok;
      tick(OS);
    end
    rxd = 1'b1;
    tick(gap);
  endtask

  // Frame-level expectation with rx_rdy held high.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    bit par_eff;
`ifdef UART_RX_PARITY_EN
    par_eff = par_ok;
    if (!par_ok) e_perr++;
`else
    par_eff = 1'b1;
`endif
    if (!stop_ok) e_ferr++;
    if (stop_ok && par_eff) exp_q.push_back(d);
  endtask

  task automatic check_counts(input string tag);
    check({tag, ":ferr"}, n_ferr, e_ferr);
    check({tag, ":perr"}, n_perr, e_perr);
    check({tag, ":ovr"},  n_ovr,  e_ovr);
    check({tag, ":nacc"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, ":byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit         sok;
    bit         pok;
    int         gb;

    // Reset values
    #2 rstn = 1'b0;
    #1;
    check("rst:vld",  rx_vld,    1'b0);
    check("rst:dout", dout,      8'h00);
    check("rst:ferr", frame_err, 1'b0);
    check("rst:perr", par_err,   1'b0);
    check("rst:ovr",  overrun,   1'b0);
    tick(3);
    rstn = 1'b1;
    tick(5);

    // Basic frame
    send_frame(8'hA5, 1, 1, -1, 10);
    model_frame(8'hA5, 1, 1);
    check_counts("a5");
    check("a5:dout", dout, 8'hA5);

    // Overrun with consumer stalled
    rx_rdy = 1'b0;
    send_frame(8'h11, 1, 1, -1, 10);
    check("ovr:vld1",  rx_vld, 1'b1);
    check("ovr:dout1", dout,   8'h11);
    send_frame(8'h22, 1, 1, -1, 10);
    e_ovr++;
    check("ovr:vld2",  rx_vld, 1'b1);
    check("ovr:dout2", dout,   8'h11);
    rx_rdy = 1'b1;
    @(negedge clk);
    check("ovr:vld_hold", rx_vld, 1'b1);
    @(negedge clk);
    check("ovr:vld_drop", rx_vld, 1'b0);
    tick(1);
    exp_q.push_back(8'h11);
    check_counts("ovr");

    // Bad stop bit, then a good frame
    send_frame(8'h3C, 0, 1, -1, 20);
    model_frame(8'h3C, 0, 1);
    check_counts("ferr");
    send_frame(8'h5A, 1, 1, -1, 10);
    model_frame(8'h5A, 1, 1);
    check_counts("after_ferr");
    check("after_ferr:dout", dout, 8'h5A);

    // Short low glitch on the idle line is a false start
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    check_counts("idle_glitch");

    // One-cycle high glitch mid-bit is outvoted
    send_frame(8'h00, 1, 1, 3, 10);
    model_frame(8'h00, 1, 1);
    check_counts("maj_glitch");
    check("maj_glitch:dout", dout, 8'h00);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1, 0, -1, 10);
    model_frame(8'h07, 1, 0);
    check_counts("par_bad");
    send_frame(8'h07, 1, 1, -1, 10);
    model_frame(8'h07, 1, 1);
    check_counts("par_good");
    check("par_good:dout", dout, 8'h07);
`endif

    // Reset during data bit 3 with a byte still held
    rx_rdy = 1'b0;
    send_frame(8'h99, 1, 1, -1, 10);
    check("mid_rst:pre_vld", rx_vld, 1'b1);
    rxd = 1'b0;
    tick(OS);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b0;
      tick(OS);
    end
    rxd = 1'b0;
    tick(5);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst:vld",  rx_vld,    1'b0);
    check("mid_rst:dout", dout,      8'h00);
    check("mid_rst:ferr", frame_err, 1'b0);
    check("mid_rst:perr", par_err,   1'b0);
    check("mid_rst:ovr",  overrun,   1'b0);
    rxd = 1'b1;
    tick(3);
    rstn   = 1'b1;
    rx_rdy = 1'b1;
    tick(20);
    got_q.delete();
    send_frame(8'hC3, 1, 1, -1, 10);
    model_frame(8'hC3, 1, 1);
    check_counts("post_rst");
    check("post_rst:dout", dout, 8'hC3);

    // Randomised frames
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom_range(0, 255));
      sok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 3) != 0);
`else
      pok = 1'b1;
`endif
      gb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DB - 1)) : -1;
      send_frame(d, sok, pok, gb, int'($urandom_range(4, 30)));
      model_frame(d, sok, pok);
      check_counts("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
